prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 24 ++
 rtl/prog_loader_byte_packer.sv | 38 +++
 rtl/prog_loader.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-image loader: FSM encoding, frame magic and defaults.
package prog_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_ADDR0 = 4'd1,
    ST_ADDR1 = 4'd2,
    ST_CNT0  = 4'd3,
    ST_CNT1  = 4'd4,
    ST_DATA  = 4'd5,
    ST_CSUM  = 4'd6,
    ST_DONE  = 4'd7,
    ST_ERR   = 4'd8
  } state_t;

  localparam logic [7:0] MAGIC       = 8'hA5;
  localparam int         DEF_ADDR_W  = 14;
  localparam int         DEF_TIMEOUT = 1024;

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Collects four little-endian bytes into one 32-bit word; word_done marks the fourth byte.
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_done
);

  logic [23:0] shift_r;
  logic [1:0]  cnt_r;

  // The fourth byte is combined combinationally; the loader registers the result.
  assign word      = {byte_data, shift_r};
  assign word_done = byte_en && (cnt_r == 2'd3);

  // Shift register and byte-position counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_r <= 24'h000000;
      cnt_r   <= 2'd0;
    end else if (clr) begin
      shift_r <= 24'h000000;
      cnt_r   <= 2'd0;
    end else if (byte_en) begin
      shift_r <= {byte_data, shift_r[23:8]};
      cnt_r   <= cnt_r + 2'd1;
    end else begin
      shift_r <= shift_r;
      cnt_r   <= cnt_r;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses a framed image, writes words to memory and
// releases the CPU only when the payload checksum matches.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_di,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t            state_r;
  logic [7:0]        addr_lo_r;
  logic [7:0]        cnt_lo_r;
  logic [7:0]        csum_r;
  logic [ADDR_W-1:0] waddr_r;
  logic [15:0]       left_r;
  logic [TW-1:0]     idle_r;

  logic              acc_s;
  logic              live_s;
  logic              word_done_s;
  logic [31:0]       word_s;
  logic [15:0]       addr16_s;
  logic [15:0]       cnt16_s;

  assign acc_s    = in_valid && in_ready;
  assign live_s   = (state_r != ST_IDLE) && (state_r != ST_DONE) && (state_r != ST_ERR);
  assign addr16_s = {in_data, addr_lo_r};
  assign cnt16_s  = {in_data, cnt_lo_r};

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (state_r == ST_IDLE),
    .byte_en   (acc_s && (state_r == ST_DATA)),
    .byte_data (in_data),
    .word      (word_s),
    .word_done (word_done_s)
  );

  // Frame-parsing FSM with registered outputs, write address and timeout counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      addr_lo_r <= 8'h00;
      cnt_lo_r  <= 8'h00;
      csum_r    <= 8'h00;
      waddr_r   <= {ADDR_W{1'b0}};
      left_r    <= 16'h0000;
      idle_r    <= {TW{1'b0}};
      in_ready  <= 1'b0;
      mem_we    <= 4'h0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_di    <= 32'h00000000;
      cpu_rst   <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 4'h0;
      if (live_s && !in_valid) begin
        // A stalled sender mid-frame is treated as a failed load.
        if (idle_r == TO_LAST) begin
          state_r  <= ST_ERR;
          err      <= 1'b1;
          cpu_rst  <= 1'b1;
          in_ready <= 1'b0;
        end else begin
          idle_r <= idle_r + {{(TW-1){1'b0}}, 1'b1};
        end
      end else begin
        idle_r <= {TW{1'b0}};
        case (state_r)
          ST_IDLE: begin
            in_ready <= 1'b1;
            csum_r   <= 8'h00;
            if (acc_s && (in_data == MAGIC)) state_r <= ST_ADDR0;
            else                             state_r <= ST_IDLE;
          end
          ST_ADDR0: begin
            addr_lo_r <= in_data;
            state_r   <= ST_ADDR1;
          end
          ST_ADDR1: begin
            waddr_r <= addr16_s[ADDR_W-1:0];
            state_r <= ST_CNT0;
          end
          ST_CNT0: begin
            cnt_lo_r <= in_data;
            state_r  <= ST_CNT1;
          end
          ST_CNT1: begin
            left_r <= cnt16_s;
            if (cnt16_s == 16'h0000) state_r <= ST_CSUM;
            else                     state_r <= ST_DATA;
          end
          ST_DATA: begin
            csum_r <= csum_step(csum_r, in_data);
            if (word_done_s) begin
              mem_we   <= 4'hF;
              mem_addr <= waddr_r;
              mem_di   <= word_s;
              waddr_r  <= waddr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
              left_r   <= left_r - 16'd1;
              if (left_r == 16'd1) state_r <= ST_CSUM;
              else                 state_r <= ST_DATA;
            end else begin
              state_r <= ST_DATA;
            end
          end
          ST_CSUM: begin
            in_ready <= 1'b0;
            if (in_data == csum_r) begin
              state_r <= ST_DONE;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state_r <= ST_ERR;
              err     <= 1'b1;
              cpu_rst <= 1'b1;
            end
          end
          ST_DONE: begin
            state_r <= ST_DONE;
          end
          ST_ERR: begin
            state_r <= ST_ERR;
          end
          default: begin
            state_r  <= ST_ERR;
            err      <= 1'b1;
            cpu_rst  <= 1'b1;
            in_ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
